b11_scrambler_p: RTL and testbench

Parametrised successor to the b11 string-scrambler benchmark. It accepts one W-bit word per transaction over a valid/ready handshake and classifies it. Accepted words run through a fixed multi-cycle arithmetic pipeline driven by a state machine, and a W-bit result is emitted over a second valid/ready handshake. It sits as a concolic-test DUT alongside the ITC99 family, keeping the b11 data path but adding backpressure, a drop indication, signed reduction in both directions and width generality.

---
 rtl/b11_scrambler_pkg.sv | 32 +++
 rtl/b11_abs_trunc.sv | 24 ++
 rtl/b11_scrambler_p.sv | 222 ++++++++++++++++++++++
 tb/tb_b11_scrambler_p.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/b11_scrambler_pkg.sv
// ---------------------------------------------------------------------------
// b11_scrambler_pkg
// Shared definitions for the b11_scrambler_p block:
//   state_e    - FSM state encoding
//   OFF0..OFF3 - signed offsets added in OFFSET, selected by r[3:2]
//   acc_width  - accumulator width derived from the data word width
// ---------------------------------------------------------------------------
package b11_scrambler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLASSIFY,
    SEED,
    MIX,
    REDUCE_DN,
    REDUCE_UP,
    OFFSET,
    EMIT
  } state_e;

  localparam int OFF0 = -21;
  localparam int OFF1 = -42;
  localparam int OFF2 = 7;
  localparam int OFF3 = 28;

  // Three guard bits keep the MIX/OFFSET intermediates (roughly +-3*2^W)
  // representable as signed values.
  function automatic int acc_width(input int w);
    return w + 3;
  endfunction

endpackage

// File: rtl/b11_abs_trunc.sv
// ---------------------------------------------------------------------------
// b11_abs_trunc
// Combinational signed magnitude of a two's-complement accumulator value,
// truncated to the W-bit result width.
//   x : input  [ACC_W-1:0]  signed accumulator value
//   y : output [W-1:0]      |x| modulo 2^W
// ---------------------------------------------------------------------------
module b11_abs_trunc #(
  parameter int W     = 6,
  parameter int ACC_W = 9
) (
  input  logic [ACC_W-1:0] x,
  output logic [W-1:0]     y
);

  logic [ACC_W-1:0] mag;
  logic             mag_unused;

  assign mag        = x[ACC_W-1] ? (~x + 1'b1) : x;
  assign y          = mag[W-1:0];
  // Bits above W are intentionally discarded by the truncation.
  assign mag_unused = ^mag[ACC_W-1:W];

endmodule

// File: rtl/b11_scrambler_p.sv
// ---------------------------------------------------------------------------
// b11_scrambler_p
// Parametrised b11-style word scrambler. A word accepted over in_valid /
// in_ready is classified: zero / all-ones words bump a wrapping run counter
// and are echoed, out-of-range words are dropped (one-cycle drop pulse), and
// in-range words run through SEED -> MIX -> REDUCE -> OFFSET. The magnitude
// of the accumulator is presented on out_data / out_valid and held until
// out_ready.
//
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous active-low reset
//   in_data   [W-1:0] input word       in_valid / in_ready  input handshake
//   out_data  [W-1:0] result word      out_valid / out_ready output handshake
//   drop      one-cycle pulse (during CLASSIFY) for a rejected word
//   busy      high whenever the FSM is not in IDLE
//
// Optional build macro B11_SCRAMBLER_P_STATS_EN adds saturating statistics
// outputs n_acc[15:0], n_drop[15:0] and max_iter[7:0].
// ---------------------------------------------------------------------------
module b11_scrambler_p
  import b11_scrambler_pkg::*;
#(
  parameter int W       = 6,
  parameter int LIMIT   = 26,
  parameter int CNT_MAX = 25
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         drop,
  output logic         busy
`ifdef B11_SCRAMBLER_P_STATS_EN
  ,
  output logic [15:0]  n_acc,
  output logic [15:0]  n_drop,
  output logic [7:0]   max_iter
`endif
);

  localparam int ACC_W = acc_width(W);

  localparam logic [W-1:0]            LIMIT_W   = W'(LIMIT);
  localparam logic [W-1:0]            CNT_MAX_W = W'(CNT_MAX);
  localparam logic signed [ACC_W-1:0] LIMIT_S   = ACC_W'(LIMIT);

  state_e                  state_reg;
  logic [W-1:0]            r_reg;
  logic [W-1:0]            cnt_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic [W-1:0]            out_data_reg;
  logic                    out_valid_reg;
  logic                    drop_reg;
  logic                    in_ready_reg;
  logic                    busy_reg;

  logic signed [ACC_W-1:0] r_ext;
  logic signed [ACC_W-1:0] cnt_ext;
  logic signed [ACC_W-1:0] off_val;
  logic [W-1:0]            abs_val;
  logic                    r_is_run;
  logic                    in_is_drop;

  assign r_ext    = {{(ACC_W-W){1'b0}}, r_reg};
  assign cnt_ext  = {{(ACC_W-W){1'b0}}, cnt_reg};
  assign r_is_run = (r_reg == '0) || (&r_reg);

  // Classification of the incoming word is done at accept time so the drop
  // pulse can be registered and still coincide with the CLASSIFY cycle.
  assign in_is_drop = !((in_data == '0) || (&in_data)) && (in_data > LIMIT_W);

  always_comb begin
    off_val = ACC_W'(OFF0);
    case (r_reg[3:2])
      2'b00:   off_val = ACC_W'(OFF0);
      2'b01:   off_val = ACC_W'(OFF1);
      2'b10:   off_val = ACC_W'(OFF2);
      default: off_val = ACC_W'(OFF3);
    endcase
  end

  b11_abs_trunc #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_abs (
    .x (acc_reg),
    .y (abs_val)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      r_reg         <= '0;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      drop_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      busy_reg      <= 1'b0;
    end else begin
      drop_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            r_reg        <= in_data;
            drop_reg     <= in_is_drop;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          if (r_is_run) begin
            cnt_reg   <= (cnt_reg < CNT_MAX_W) ? cnt_reg + 1'b1 : '0;
            acc_reg   <= r_ext;
            state_reg <= EMIT;
          end else if (r_reg <= LIMIT_W) begin
            state_reg <= SEED;
          end else begin
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        SEED: begin
          acc_reg   <= r_reg[0] ? (cnt_ext <<< 1) : cnt_ext;
          state_reg <= MIX;
        end
        MIX: begin
          if (r_reg[1]) begin
            acc_reg   <= r_ext + acc_reg;
            state_reg <= REDUCE_DN;
          end else begin
            acc_reg   <= r_ext - acc_reg;
            state_reg <= REDUCE_UP;
          end
        end
        REDUCE_DN: begin
          if (acc_reg > LIMIT_S) acc_reg <= acc_reg - LIMIT_S;
          else                   state_reg <= OFFSET;
        end
        REDUCE_UP: begin
          if (acc_reg[ACC_W-1]) acc_reg <= acc_reg + LIMIT_S;
          else                  state_reg <= OFFSET;
        end
        OFFSET: begin
          acc_reg   <= acc_reg + off_val;
          state_reg <= EMIT;
        end
        EMIT: begin
          // First EMIT cycle loads the result; afterwards wait for the sink.
          if (!out_valid_reg) begin
            out_data_reg  <= abs_val;
            out_valid_reg <= 1'b1;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          in_ready_reg <= 1'b1;
          busy_reg     <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign drop      = drop_reg;
  assign busy      = busy_reg;

`ifdef B11_SCRAMBLER_P_STATS_EN
  logic [15:0] n_acc_reg;
  logic [15:0] n_drop_reg;
  logic [7:0]  max_iter_reg;
  logic [7:0]  iter_reg;
  logic        in_reduce;
  logic        reduce_stay;

  assign in_reduce   = (state_reg == REDUCE_DN) || (state_reg == REDUCE_UP);
  assign reduce_stay = ((state_reg == REDUCE_DN) && (acc_reg > LIMIT_S)) ||
                       ((state_reg == REDUCE_UP) && acc_reg[ACC_W-1]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      n_acc_reg    <= '0;
      n_drop_reg   <= '0;
      max_iter_reg <= '0;
      iter_reg     <= '0;
    end else begin
      if ((state_reg == IDLE) && in_valid && in_ready_reg && (n_acc_reg != 16'hFFFF))
        n_acc_reg <= n_acc_reg + 16'd1;
      // drop_reg is high for exactly one cycle per rejected word.
      if (drop_reg && (n_drop_reg != 16'hFFFF))
        n_drop_reg <= n_drop_reg + 16'd1;
      if (state_reg == MIX) begin
        iter_reg <= '0;
      end else if (reduce_stay) begin
        if (iter_reg != 8'hFF) iter_reg <= iter_reg + 8'd1;
      end else if (in_reduce && (iter_reg > max_iter_reg)) begin
        max_iter_reg <= iter_reg;
      end
    end
  end

  assign n_acc    = n_acc_reg;
  assign n_drop   = n_drop_reg;
  assign max_iter = max_iter_reg;
`endif

endmodule

// File: tb/tb_b11_scrambler_p.sv
// ---------------------------------------------------------------------------
// tb_b11_scrambler_p
// Directed self-checking bench for b11_scrambler_p (W=6, LIMIT=26,
// CNT_MAX=25). Expected values are hand-computed from the block behaviour.
// ---------------------------------------------------------------------------
module tb_b11_scrambler_p;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       drop;
  logic       busy;
`ifdef B11_SCRAMBLER_P_STATS_EN
  logic [15:0] n_acc;
  logic [15:0] n_drop;
  logic [7:0]  max_iter;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  b11_scrambler_p #(
    .W       (6),
    .LIMIT   (26),
    .CNT_MAX (25)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop      (drop),
    .busy      (busy)
`ifdef B11_SCRAMBLER_P_STATS_EN
    ,
    .n_acc     (n_acc),
    .n_drop    (n_drop),
    .max_iter  (max_iter)
`endif
  );

  task automatic do_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Offers one word, waits (bounded) for the result and completes the output
  // handshake. lat is the number of edges from accept to out_valid, -1 if
  // the result never appeared.
  task automatic xfer(input logic [5:0] d, input logic rdy,
                      output logic [5:0] res, output int lat);
    @(negedge clock);
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = rdy;
    @(posedge clock);
    #1 in_valid = 1'b0;
    lat = -1;
    res = 'x;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (out_valid) begin
        lat = i;
        res = out_data;
        break;
      end
    end
    if (lat > 0) begin
      out_ready = 1'b1;
      if (!rdy) begin
        @(posedge clock);
        #1;
      end else begin
        // Handshake already in progress this cycle; let it complete.
        @(posedge clock);
        #1;
      end
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [5:0] res;
    int lat;
    do_reset();
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || drop !== 1'b0 || out_data !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_values: in_ready=%b busy=%b out_valid=%b drop=%b out_data=%0d, required 1 0 0 0 0",
               in_ready, busy, out_valid, drop, out_data);
    end
    // zero word bumps cnt to 1, then 5 -> acc 2 -> 3 -> -39 -> 39
    xfer(6'd0, 1'b1, res, lat);
    xfer(6'd5, 1'b0, res, lat);
    n_cmp++;
    if (res !== 6'd39 || lat !== 6) begin
      n_bad++;
      $display("FAIL reset_pre_word: out_data=%0d lat=%0d, required 39 lat 6", res, lat);
    end
    // start another word and pull reset while in MIX
    @(negedge clock);
    in_data  = 6'd5;
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_busy: busy=%b in_ready=%b, required 1 0", busy, in_ready);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || drop !== 1'b0 || out_data !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_async: in_ready=%b busy=%b out_valid=%b drop=%b out_data=%0d, required 1 0 0 0 0",
               in_ready, busy, out_valid, drop, out_data);
    end
    @(negedge clock);
    reset = 1'b1;
    // cnt back at 0: 5 -> 37
    xfer(6'd5, 1'b0, res, lat);
    n_cmp++;
    if (res !== 6'd37 || lat !== 6) begin
      n_bad++;
      $display("FAIL reset_cnt_cleared: out_data=%0d lat=%0d, required 37 lat 6", res, lat);
    end
    $display("test_reset done");
  endtask

  task automatic test_normal();
    logic [5:0] res;
    int lat;
    do_reset();
    xfer(6'd5, 1'b0, res, lat);
    n_cmp++;
    if (res !== 6'd37 || lat !== 6) begin
      n_bad++;
      $display("FAIL normal_5: out_data=%0d lat=%0d, required 37 lat 6", res, lat);
    end
    // r == LIMIT, cnt 0: 0 -> 26 (no reduction) -> 33
    xfer(6'd26, 1'b0, res, lat);
    n_cmp++;
    if (res !== 6'd33 || lat !== 6) begin
      n_bad++;
      $display("FAIL normal_limit: out_data=%0d lat=%0d, required 33 lat 6", res, lat);
    end
    $display("test_normal done");
  endtask

  task automatic test_run_reduce();
    logic [5:0] res;
    int lat;
    do_reset();
    xfer(6'd0, 1'b1, res, lat);
    n_cmp++;
    if (res !== 6'd0 || lat !== 2) begin
      n_bad++;
      $display("FAIL run_zero: out_data=%0d lat=%0d, required 0 lat 2", res, lat);
    end
    // cnt 1: acc 1 -> 27 -> 1 (one step) -> 8
    xfer(6'd26, 1'b1, res, lat);
    n_cmp++;
    if (res !== 6'd8 || lat !== 7) begin
      n_bad++;
      $display("FAIL reduce_dn: out_data=%0d lat=%0d, required 8 lat 7", res, lat);
    end
    $display("test_run_reduce done");
  endtask

  task automatic test_drop();
    logic [5:0] res;
    int lat;
    logic [5:0] words [2];
    words[0] = 6'd40;
    words[1] = 6'd27;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      in_data  = words[k];
      in_valid = 1'b1;
      @(posedge clock);
      #1 in_valid = 1'b0;
      n_cmp++;
      if (drop !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL drop_pulse_%0d: drop=%b in_ready=%b out_valid=%b, required 1 0 0",
                 words[k], drop, in_ready, out_valid);
      end
      @(posedge clock);
      #1;
      n_cmp++;
      if (drop !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL drop_after_%0d: drop=%b in_ready=%b busy=%b out_valid=%b, required 0 1 0 0",
                 words[k], drop, in_ready, busy, out_valid);
      end
    end
    // cnt 0: 3 -> acc 0 -> 3 -> -18 -> 18
    xfer(6'd3, 1'b0, res, lat);
    n_cmp++;
    if (res !== 6'd18 || lat !== 6) begin
      n_bad++;
      $display("FAIL drop_then_3: out_data=%0d lat=%0d, required 18 lat 6", res, lat);
    end
    $display("test_drop done");
  endtask

  task automatic test_cnt_wrap();
    logic [5:0] res;
    int lat;
    do_reset();
    for (int k = 1; k <= 26; k++) begin
      xfer(6'd0, 1'b1, res, lat);
      n_cmp++;
      if (res !== 6'd0 || lat !== 2) begin
        n_bad++;
        $display("FAIL wrap_zero_%0d: out_data=%0d lat=%0d, required 0 lat 2", k, res, lat);
      end
    end
    // cnt wrapped to 0
    xfer(6'd5, 1'b1, res, lat);
    n_cmp++;
    if (res !== 6'd37 || lat !== 6) begin
      n_bad++;
      $display("FAIL wrap_cnt0: out_data=%0d lat=%0d, required 37 lat 6", res, lat);
    end
    for (int k = 1; k <= 25; k++) xfer(6'd0, 1'b1, res, lat);
    // cnt 25: 50 -> -45 -> -19 -> 7 (two steps) -> -35 -> 35
    xfer(6'd5, 1'b1, res, lat);
    n_cmp++;
    if (res !== 6'd35 || lat !== 8) begin
      n_bad++;
      $display("FAIL reduce_up_cnt25: out_data=%0d lat=%0d, required 35 lat 8", res, lat);
    end
    xfer(6'd63, 1'b1, res, lat);
    n_cmp++;
    if (res !== 6'd63 || lat !== 2) begin
      n_bad++;
      $display("FAIL all_ones: out_data=%0d lat=%0d, required 63 lat 2", res, lat);
    end
    xfer(6'd5, 1'b1, res, lat);
    n_cmp++;
    if (res !== 6'd37 || lat !== 6) begin
      n_bad++;
      $display("FAIL wrap_after_63: out_data=%0d lat=%0d, required 37 lat 6", res, lat);
    end
    $display("test_cnt_wrap done");
  endtask

  task automatic test_back_to_back();
    logic [5:0] res;
    int lat;
    int held_bad;
    do_reset();
    @(negedge clock);
    in_data  = 6'd26;
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    n_cmp++;
    if (out_data !== 6'd33 || lat !== 6) begin
      n_bad++;
      $display("FAIL bp_result: out_data=%0d lat=%0d, required 33 lat 6", out_data, lat);
    end
    held_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      in_valid = i[0];
      in_data  = (i % 3 == 0) ? 6'd0 : 6'(i + 1);
      @(posedge clock);
      #1;
      if (out_valid !== 1'b1 || out_data !== 6'd33 || in_ready !== 1'b0) held_bad++;
    end
    n_cmp++;
    if (held_bad !== 0) begin
      n_bad++;
      $display("FAIL bp_hold: %0d cycles unstable (out_valid=%b out_data=%0d in_ready=%b), required 0",
               held_bad, out_valid, out_data, in_ready);
    end
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    repeat (5) @(posedge clock);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_no_capture: out_valid=%b busy=%b, required 0 0", out_valid, busy);
    end
    // cnt untouched by the ignored zero words
    xfer(6'd5, 1'b1, res, lat);
    n_cmp++;
    if (res !== 6'd37 || lat !== 6) begin
      n_bad++;
      $display("FAIL bp_cnt_intact: out_data=%0d lat=%0d, required 37 lat 6", res, lat);
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_normal();
    test_run_reduce();
    test_drop();
    test_cnt_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
